// File: rtl/c0_5_monitor.sv
// Checker and resynchroniser for the mod-6 up/down counter c0_5.
// Define C0_5_MONITOR_RESYNC_EN to force the counter back to 0 through `load` after an error.
module c0_5_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       reverse,
    input  logic [4:1] Q,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [3:0] expected,
    output logic [7:0] load,
    output logic       resync
);

    localparam logic [1:0] ACQUIRE = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] ERROR   = 2'd2;
    localparam logic [1:0] RESYNC  = 2'd3;

    logic [1:0] state;
    logic [3:0] q_d;
    logic       en_d;
    logic       rev_d;
    logic [3:0] q_now;
    logic [3:0] pred;
    logic       legal;
    logic       detect;

    function automatic logic [3:0] inc6(input logic [3:0] v);
        return (v == 4'd5) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] dec6(input logic [3:0] v);
        return (v == 4'd0) ? 4'd5 : v - 4'd1;
    endfunction

    // An illegal code can never equal pred, so the mismatch test also covers it in TRACK.
    always_comb begin
        q_now  = Q;
        legal  = (Q[4] == 1'b0) && (Q[3:1] <= 3'd5);
        pred   = en_d ? (rev_d ? dec6(q_d) : inc6(q_d)) : q_d;
        detect = 1'b0;
        if (state == ACQUIRE)
            detect = !legal;
        else if (state == TRACK)
            detect = !legal || (q_now != pred);
    end

    assign locked = (state == TRACK);

`ifdef C0_5_MONITOR_RESYNC_EN
    localparam logic [7:0] LOAD_CLEAR = 8'h2A;
    logic rs_cnt;

    // load is held for exactly two cycles: the RESYNC entry cycle and one more.
    always_ff @(posedge clk) begin
        if (reset) begin
            load   <= 8'h00;
            resync <= 1'b0;
            rs_cnt <= 1'b0;
        end else if (state == ERROR) begin
            load   <= LOAD_CLEAR;
            resync <= 1'b1;
            rs_cnt <= 1'b0;
        end else if (state == RESYNC) begin
            if (rs_cnt) begin
                load   <= 8'h00;
                resync <= 1'b0;
                rs_cnt <= 1'b0;
            end else begin
                rs_cnt <= 1'b1;
            end
        end
    end
`else
    assign load   = 8'h00;
    assign resync = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACQUIRE;
            err       <= 1'b0;
            err_count <= 8'd0;
            expected  <= 4'd0;
            q_d       <= 4'd0;
            en_d      <= 1'b0;
            rev_d     <= 1'b0;
        end else begin
            q_d   <= q_now;
            en_d  <= enable;
            rev_d <= reverse;
            err   <= detect;
            if (detect && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
            case (state)
                ACQUIRE: state <= legal ? TRACK : ERROR;
                TRACK: begin
                    expected <= pred;
                    if (detect)
                        state <= ERROR;
                end
`ifdef C0_5_MONITOR_RESYNC_EN
                ERROR:  state <= RESYNC;
                RESYNC: if (rs_cnt) state <= ACQUIRE;
`else
                ERROR:  state <= ACQUIRE;
                RESYNC: state <= ACQUIRE;
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_c0_5_monitor.sv
// Scoreboard bench for c0_5_monitor: a behavioural model queues the expected outputs per edge.
// Honours C0_5_MONITOR_RESYNC_EN the same way as the design.
module tb_c0_5_monitor;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       reverse;
    logic [4:1] Q;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [3:0] expected;
    logic [7:0] load;
    logic       resync;

    c0_5_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .reverse   (reverse),
        .Q         (Q),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .expected  (expected),
        .load      (load),
        .resync    (resync)
    );

    typedef enum {M_ACQ, M_TRACK, M_ERR, M_RESYNC} mstate_t;

    typedef struct {
        logic       locked;
        logic       err;
        logic [7:0] cnt;
        logic [3:0] expv;
        logic [7:0] load;
        logic       resync;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      ctr = 0;

    mstate_t ms = M_ACQ;
    int      m_qd = 0;
    logic    m_en = 1'b0;
    logic    m_rev = 1'b0;
    logic    m_err = 1'b0;
    int      m_cnt = 0;
    int      m_exp = 0;
    logic [7:0] m_load = 8'h00;
    logic    m_resync = 1'b0;
    int      m_left = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] want);
        checks++;
        if (observed !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, want);
        end
    endtask

    // Drives one cycle of inputs and advances the model to what the DUT should show after the next edge.
    task automatic applyStimulus(input logic [3:0] q, input logic en, input logic rev, input logic rst);
        exp_t e;
        int   p;
        logic hit;
        Q       = q;
        enable  = en;
        reverse = rev;
        reset   = rst;
        if (rst) begin
            ms = M_ACQ; m_qd = 0; m_en = 0; m_rev = 0; m_err = 0;
            m_cnt = 0; m_exp = 0; m_load = 8'h00; m_resync = 0; m_left = 0;
        end else begin
            p   = m_en ? (m_rev ? (m_qd + 5) % 6 : (m_qd + 1) % 6) : m_qd;
            hit = 1'b0;
            case (ms)
                M_ACQ: begin
                    if (int'(q) < 6) ms = M_TRACK;
                    else begin hit = 1'b1; ms = M_ERR; end
                end
                M_TRACK: begin
                    m_exp = p;
                    if (int'(q) != p) begin hit = 1'b1; ms = M_ERR; end
                end
                M_ERR: begin
`ifdef C0_5_MONITOR_RESYNC_EN
                    ms = M_RESYNC; m_load = 8'h2A; m_resync = 1'b1; m_left = 2;
`else
                    ms = M_ACQ;
`endif
                end
                M_RESYNC: begin
                    m_left--;
                    if (m_left == 0) begin ms = M_ACQ; m_load = 8'h00; m_resync = 1'b0; end
                end
            endcase
            m_err = hit;
            if (hit && m_cnt < 255) m_cnt++;
            m_qd = int'(q); m_en = en; m_rev = rev;
        end
        e.locked = (ms == M_TRACK);
        e.err    = m_err;
        e.cnt    = 8'(m_cnt);
        e.expv   = 4'(m_exp);
        e.load   = m_load;
        e.resync = m_resync;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] q, input logic en, input logic rev, input logic rst);
        exp_t e;
        applyStimulus(q, en, rev, rst);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("locked", 32'(locked), 32'(e.locked));
            checkOutput("err", 32'(err), 32'(e.err));
            checkOutput("err_count", 32'(err_count), 32'(e.cnt));
            checkOutput("expected", 32'(expected), 32'(e.expv));
            checkOutput("load", 32'(load), 32'(e.load));
            checkOutput("resync", 32'(resync), 32'(e.resync));
        end
    endtask

    // Plays the counter itself: ctr is what the counter shows, stepping after each edge it is enabled at.
    task automatic runCounter(input logic en, input logic rev, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(4'(ctr), en, rev, 1'b0);
            if (en) ctr = rev ? (ctr + 5) % 6 : (ctr + 1) % 6;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; reverse = 1'b0; Q = 4'd0;
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd0, 1'b0, 1'b0, 1'b1);

        ctr = 0;
        runCounter(1'b1, 1'b0, 7);
        checkOutput("up_locked", 32'(locked), 32'd1);
        runCounter(1'b1, 1'b1, 4);
        runCounter(1'b0, 1'b0, 3);
        checkOutput("hold_count", 32'(err_count), 32'd0);

        cycle(4'd3, 1'b1, 1'b0, 1'b0);
        cycle(4'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("jump_err", 32'(err), 32'd1);
        checkOutput("jump_locked", 32'(locked), 32'd0);
        ctr = 0;
        runCounter(1'b0, 1'b0, 4);
        checkOutput("jump_pulse", 32'(err), 32'd0);
        runCounter(1'b1, 1'b0, 3);
        runCounter(1'b0, 1'b1, 2);
        runCounter(1'b1, 1'b1, 3);

        cycle(4'b0111, 1'b1, 1'b0, 1'b0);
        ctr = 0;
        runCounter(1'b0, 1'b0, 5);
        runCounter(1'b1, 1'b0, 3);
        checkOutput("relock", 32'(locked), 32'd1);

        for (int i = 0; i < 1300; i++) cycle(4'hF, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_count", 32'(err_count), 32'd255);
        ctr = 0;
        runCounter(1'b1, 1'b0, 4);

        cycle(4'h8, 1'b0, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b0, 1'b0);
        cycle(4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_load", 32'(load), 32'd0);
        checkOutput("rst_count", 32'(err_count), 32'd0);
        ctr = 0;
        runCounter(1'b1, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, expected end before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
